cp0_exc_unit: RTL and testbench
===============================

// Module: cp0_exc_unit
// PURPOSE
//  Consumes EXCCODE/ERET/MTC0/MFC0 produced by ctrl, carried down the pipe to MEM stage.
//  Holds CP0 Status(12)/Cause(13)/EPC(14); commits exceptions and ERET, then issues a
//  registered pipeline flush plus PC redirect to the fetch stage.
// PARAMETERS
//  EXC_VECTOR  32'h0000_4180  redirect target for every exception
//  STATUS_RST  32'h0000_0000  Status reset value
// PORTS
//  clk               in   1   clock, single domain
//  rst               in   1   reset, synchronous, active-high
//  valid_i           in   1   MEM-stage instruction valid (not a bubble)
//  pc_i              in   32  PC of MEM-stage instruction
//  in_delay_slot_i   in   1   MEM-stage instruction sits in a branch delay slot
//  excode_i          in   `SIZE_EXCCODE+1  exception code from ctrl, EXC_NOT = none
//  eret_i            in   1   ERET in MEM stage
//  mtc0_we_i         in   1   MTC0 write enable
//  cp0_addr_i        in   5   CP0 register index (rd field)
//  cp0_wdata_i       in   32  MTC0 write data
//  cp0_rdata_o       out  32  MFC0 read data, combinational; unimplemented index -> 0
//  status_o/cause_o/epc_o  out  32 each  current register values
//  exc_flush_o       out  1   flush IF..MEM, one-cycle pulse
//  redirect_valid_o  out  1   redirect_pc_o valid, same cycle as flush
//  redirect_pc_o     out  32  next fetch PC
//  hw_int_i          in   6   hardware interrupt lines (CP0_HW_INT_EN only)
// BEHAVIOUR
//  Reset: Status=STATUS_RST, Cause=0, EPC=0, all outputs 0, FSM=IDLE.
//  FSM IDLE->TAKE on exception accept; IDLE->RET on ERET accept; TAKE/RET->IDLE next cycle.
//  Accept only when state==IDLE && valid_i; inputs in TAKE/RET are ignored (flushed).
//  Latency: event sampled at edge N; flush/redirect high for cycle N+1 only.
//  Exception (excode_i!=EXC_NOT): Cause.ExcCode[6:2]<=excode_i; Status.EXL[1]<=1;
//   if EXL was 0: EPC<=in_delay_slot_i ? pc_i-4 : pc_i, Cause.BD[31]<=in_delay_slot_i;
//   if EXL was 1: EPC/BD unchanged. redirect_pc_o=EXC_VECTOR.
//  ERET: Status.EXL<=0; redirect_pc_o=EPC value at accept edge; Cause unchanged.
//  Priority same cycle: exception > ERET > MTC0; lower-priority actions dropped.
//  MTC0 masks: Status writes IM[15:8],EXL[1],IE[0]; Cause writes IP[9:8] only;
//   EPC fully writable; other indices ignored. MTC0 EPC then ERET next cycle -> new EPC.
//  MFC0 read of register written same cycle returns old value (write lands at edge).
//  pc_i-4 wraps modulo 2^32. rst mid-TAKE/RET: outputs drop to 0 next edge, FSM=IDLE.
// CONFIGURATION
//  CP0_HW_INT_EN defined: hw_int_i exists, sampled each cycle into Cause.IP[15:10];
//   interrupt pending = IE && !EXL && |(IP[15:8] & IM[15:8]); taken on next accepted
//   valid_i with ExcCode=0, EPC as exception; outranks synchronous excode_i.
//  Undefined: hw_int_i absent, IP[15:10] read 0, no interrupt path.
// STRUCTURE
//  Para.v (shared include): EXC_* codes incl. EXC_INT=0, SIZE_EXCCODE, CP0 indices
//   CP0_STATUS/CP0_CAUSE/CP0_EPC, bit positions EXL/IE/BD/EXCCODE/IM/IP.
//  Sub-module cp0_regs: Status/Cause/EPC storage, write masks, read mux.
//  Top: accept logic, priority, FSM, redirect registers.
// TESTING
//  SYSCALL: valid_i=1, pc_i=0x3010, excode=EXC_SYSCALL -> next cycle flush=1,
//   redirect=0x4180, EPC=0x3010, ExcCode=8, EXL=1.
//  Delay slot BREAK pc_i=0x3014, in_delay_slot_i=1 -> EPC=0x3010, BD=1, ExcCode=9.
//  ERET with EPC=0x3020, EXL=1 -> flush=1, redirect=0x3020, EXL=0, one-cycle pulse.
//  Nested: exception while EXL=1, pc_i=0x5000 -> EPC unchanged, ExcCode updated, redirect 0x4180.
//  MTC0 Status 0xFFFF_FFFF -> Status=0x0000_FF03; MTC0 Cause 0xFFFF_FFFF -> Cause=0x300.
//  Exception+ERET same cycle -> exception taken, EXL=1; rst during TAKE -> all outputs 0.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// CP0 exception unit shared definitions: exception codes, CP0 indices,
// register bit positions, write masks and FSM state type.
package cp0_exc_unit_pkg;

  localparam int SIZE_EXCCODE = 4;

  localparam logic [SIZE_EXCCODE:0] EXC_INT     = 5'd0;
  localparam logic [SIZE_EXCCODE:0] EXC_ADEL    = 5'd4;
  localparam logic [SIZE_EXCCODE:0] EXC_ADES    = 5'd5;
  localparam logic [SIZE_EXCCODE:0] EXC_SYSCALL = 5'd8;
  localparam logic [SIZE_EXCCODE:0] EXC_BREAK   = 5'd9;
  localparam logic [SIZE_EXCCODE:0] EXC_RI      = 5'd10;
  localparam logic [SIZE_EXCCODE:0] EXC_OV      = 5'd12;
  // Out-of-band code meaning "no exception on this instruction".
  localparam logic [SIZE_EXCCODE:0] EXC_NOT     = 5'h1f;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int EXCCODE_LO = 2;
  localparam int EXCCODE_HI = 6;
  localparam int IM_LO      = 8;
  localparam int IM_HI      = 15;
  localparam int IP_LO      = 8;
  localparam int IP_HI      = 15;
  localparam int IP_HW_LO   = 10;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAKE,
    ST_RET
  } state_t;

  function automatic logic [31:0] epc_target(
    input logic [31:0] pc,
    input logic        in_ds
  );
    return in_ds ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// CP0 Status/Cause/EPC storage with write masks and MFC0 read mux.
// CP0_HW_INT_EN adds hardware interrupt sampling into Cause.IP[15:10].
module cp0_regs
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_take,
  input  logic [SIZE_EXCCODE:0] exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_epc,
  input  logic                  eret_take,
  input  logic                  mtc0_take,
  input  logic [4:0]            addr,
  input  logic [31:0]           wdata,
`ifdef CP0_HW_INT_EN
  input  logic [5:0]            hw_int,
`endif
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic [31:0]           epc,
  output logic [31:0]           rdata,
  output logic                  int_pend
);

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      cause  <= '0;
      epc    <= '0;
    end else begin
      if (exc_take) begin
        cause[EXCCODE_HI:EXCCODE_LO] <= exc_code;
        status[STATUS_EXL]           <= 1'b1;
        // Nested exceptions keep the original return point.
        if (!status[STATUS_EXL]) begin
          epc             <= exc_epc;
          cause[CAUSE_BD] <= exc_bd;
        end
      end else if (eret_take) begin
        status[STATUS_EXL] <= 1'b0;
      end else if (mtc0_take) begin
        case (addr)
          CP0_STATUS: status <= (status & ~STATUS_WMASK)
                              | (wdata & STATUS_WMASK);
          CP0_CAUSE:  cause  <= (cause & ~CAUSE_WMASK)
                              | (wdata & CAUSE_WMASK);
          CP0_EPC:    epc    <= wdata;
          default:    ;
        endcase
      end
`ifdef CP0_HW_INT_EN
      cause[IP_HI:IP_HW_LO] <= hw_int;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_STATUS: rdata = status;
      CP0_CAUSE:  rdata = cause;
      CP0_EPC:    rdata = epc;
      default:    rdata = '0;
    endcase
  end

`ifdef CP0_HW_INT_EN
  assign int_pend = status[STATUS_IE] && !status[STATUS_EXL]
                 && |(cause[IP_HI:IP_LO] & status[IM_HI:IM_LO]);
`else
  assign int_pend = 1'b0;
`endif

endmodule

// File: rtl/cp0_exc_unit.sv
// MEM-stage exception/ERET commit with registered flush and PC redirect.
// CP0_HW_INT_EN enables the hw_int_i interrupt path.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_slot_i,
  input  logic [SIZE_EXCCODE:0] excode_i,
  input  logic                  eret_i,
  input  logic                  mtc0_we_i,
  input  logic [4:0]            cp0_addr_i,
  input  logic [31:0]           cp0_wdata_i,
  output logic [31:0]           cp0_rdata_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  exc_flush_o,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_pc_o
`ifdef CP0_HW_INT_EN
  ,
  input  logic [5:0]            hw_int_i
`endif
);

  state_t                state;
  logic                  accept;
  logic                  int_pend;
  logic                  exc_req;
  logic                  exc_take;
  logic                  eret_take;
  logic                  mtc0_take;
  logic [SIZE_EXCCODE:0] exc_code;

  assign accept    = (state == ST_IDLE) && valid_i;
  assign exc_req   = int_pend || (excode_i != EXC_NOT);
  assign exc_code  = int_pend ? EXC_INT : excode_i;
  assign exc_take  = accept && exc_req;
  assign eret_take = accept && !exc_req && eret_i;
  assign mtc0_take = accept && !exc_req && !eret_i && mtc0_we_i;

  cp0_regs #(
    .STATUS_RST (STATUS_RST)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .exc_take  (exc_take),
    .exc_code  (exc_code),
    .exc_bd    (in_delay_slot_i),
    .exc_epc   (epc_target(pc_i, in_delay_slot_i)),
    .eret_take (eret_take),
    .mtc0_take (mtc0_take),
    .addr      (cp0_addr_i),
    .wdata     (cp0_wdata_i),
`ifdef CP0_HW_INT_EN
    .hw_int    (hw_int_i),
`endif
    .status    (status_o),
    .cause     (cause_o),
    .epc       (epc_o),
    .rdata     (cp0_rdata_o),
    .int_pend  (int_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      exc_flush_o      <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (exc_take) begin
            state            <= ST_TAKE;
            exc_flush_o      <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= EXC_VECTOR;
          end else if (eret_take) begin
            state            <= ST_RET;
            exc_flush_o      <= 1'b1;
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= epc_o;
          end
        end
        ST_TAKE, ST_RET: begin
          state            <= ST_IDLE;
          exc_flush_o      <= 1'b0;
          redirect_valid_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed testbench for cp0_exc_unit: exceptions, ERET, nesting,
// MTC0 masks, priority and reset behaviour.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic [4:0]  excode_i;
  logic        eret_i;
  logic        mtc0_we_i;
  logic [4:0]  cp0_addr_i;
  logic [31:0] cp0_wdata_i;
  logic [31:0] cp0_rdata_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        exc_flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
`ifdef CP0_HW_INT_EN
  logic [5:0]  hw_int_i = 6'd0;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] NONE = 5'h1f;

  cp0_exc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .pc_i             (pc_i),
    .in_delay_slot_i  (in_delay_slot_i),
    .excode_i         (excode_i),
    .eret_i           (eret_i),
    .mtc0_we_i        (mtc0_we_i),
    .cp0_addr_i       (cp0_addr_i),
    .cp0_wdata_i      (cp0_wdata_i),
    .cp0_rdata_o      (cp0_rdata_o),
    .status_o         (status_o),
    .cause_o          (cause_o),
    .epc_o            (epc_o),
    .exc_flush_o      (exc_flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
`ifdef CP0_HW_INT_EN
    ,
    .hw_int_i         (hw_int_i)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid_i = 0; pc_i = 0; in_delay_slot_i = 0; excode_i = NONE;
    eret_i = 0; mtc0_we_i = 0; cp0_addr_i = 0; cp0_wdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({status_o, cause_o, epc_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h want 0 0 0", status_o, cause_o, epc_o);
    end
    checks++;
    if ({exc_flush_o, redirect_valid_o, redirect_pc_o} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outs got %b %b %h want 0 0 0",
               exc_flush_o, redirect_valid_o, redirect_pc_o);
    end
  endtask

  task automatic test_valid_low();
    idle_inputs(); excode_i = 5'd8; pc_i = 32'h100;
    tick();
    checks++;
    if (exc_flush_o !== 1'b0 || epc_o !== 32'h0) begin
      errors++;
      $display("FAIL bubble_ignored got flush=%b epc=%h want 0 0", exc_flush_o, epc_o);
    end
    idle_inputs();
  endtask

  task automatic test_syscall();
    idle_inputs(); valid_i = 1; pc_i = 32'h3010; excode_i = 5'd8;
    tick();
    idle_inputs();
    checks++;
    if (exc_flush_o !== 1 || redirect_valid_o !== 1 || redirect_pc_o !== 32'h4180) begin
      errors++;
      $display("FAIL syscall_redirect got %b %b %h want 1 1 00004180",
               exc_flush_o, redirect_valid_o, redirect_pc_o);
    end
    checks++;
    if (epc_o !== 32'h3010 || cause_o[6:2] !== 5'd8 || status_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL syscall_regs got epc=%h code=%0d exl=%b want 3010 8 1",
               epc_o, cause_o[6:2], status_o[1]);
    end
    tick();
    checks++;
    if (exc_flush_o !== 0 || redirect_valid_o !== 0) begin
      errors++;
      $display("FAIL syscall_pulse got %b %b want 0 0", exc_flush_o, redirect_valid_o);
    end
  endtask

  task automatic test_mtc0_epc_eret();
    idle_inputs(); valid_i = 1; mtc0_we_i = 1;
    cp0_addr_i = 5'd14; cp0_wdata_i = 32'h3020;
    tick();
    idle_inputs();
    checks++;
    if (epc_o !== 32'h3020 || exc_flush_o !== 0) begin
      errors++;
      $display("FAIL mtc0_epc got epc=%h flush=%b want 3020 0", epc_o, exc_flush_o);
    end
    valid_i = 1; eret_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_flush_o !== 1 || redirect_valid_o !== 1 || redirect_pc_o !== 32'h3020
        || status_o[1] !== 0) begin
      errors++;
      $display("FAIL eret got %b %b %h exl=%b want 1 1 00003020 0",
               exc_flush_o, redirect_valid_o, redirect_pc_o, status_o[1]);
    end
    checks++;
    if (cause_o[6:2] !== 5'd8) begin
      errors++;
      $display("FAIL eret_cause got %0d want 8", cause_o[6:2]);
    end
    tick();
    checks++;
    if (exc_flush_o !== 0) begin
      errors++;
      $display("FAIL eret_pulse got %b want 0", exc_flush_o);
    end
  endtask

  task automatic test_delay_slot();
    idle_inputs(); valid_i = 1; pc_i = 32'h3014;
    in_delay_slot_i = 1; excode_i = 5'd9;
    tick();
    idle_inputs();
    checks++;
    if (epc_o !== 32'h3010 || cause_o[31] !== 1 || cause_o[6:2] !== 5'd9
        || redirect_pc_o !== 32'h4180) begin
      errors++;
      $display("FAIL delay_slot got epc=%h bd=%b code=%0d rpc=%h want 3010 1 9 4180",
               epc_o, cause_o[31], cause_o[6:2], redirect_pc_o);
    end
    tick();
  endtask

  task automatic test_nested();
    idle_inputs(); valid_i = 1; pc_i = 32'h5000; excode_i = 5'd8;
    tick();
    checks++;
    if (epc_o !== 32'h3010 || cause_o[31] !== 1 || cause_o[6:2] !== 5'd8
        || exc_flush_o !== 1 || redirect_pc_o !== 32'h4180) begin
      errors++;
      $display("FAIL nested got epc=%h bd=%b code=%0d flush=%b rpc=%h want 3010 1 8 1 4180",
               epc_o, cause_o[31], cause_o[6:2], exc_flush_o, redirect_pc_o);
    end
    // Inputs during the TAKE cycle belong to flushed instructions.
    idle_inputs(); valid_i = 1; mtc0_we_i = 1;
    cp0_addr_i = 5'd14; cp0_wdata_i = 32'hdead_beef;
    tick();
    idle_inputs();
    checks++;
    if (epc_o !== 32'h3010 || exc_flush_o !== 0) begin
      errors++;
      $display("FAIL take_ignore got epc=%h flush=%b want 3010 0", epc_o, exc_flush_o);
    end
  endtask

  task automatic test_mtc0_masks();
    do_reset();
    valid_i = 1; mtc0_we_i = 1; cp0_addr_i = 5'd12; cp0_wdata_i = 32'hffff_ffff;
    tick();
    checks++;
    if (status_o !== 32'h0000_ff03) begin
      errors++;
      $display("FAIL status_mask got %h want 0000ff03", status_o);
    end
    cp0_addr_i = 5'd13;
    tick();
    checks++;
    if (cause_o !== 32'h0000_0300) begin
      errors++;
      $display("FAIL cause_mask got %h want 00000300", cause_o);
    end
    cp0_addr_i = 5'd12; cp0_wdata_i = 32'h0;
    #1;
    checks++;
    if (cp0_rdata_o !== 32'h0000_ff03) begin
      errors++;
      $display("FAIL mfc0_old got %h want 0000ff03", cp0_rdata_o);
    end
    tick();
    checks++;
    if (cp0_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mfc0_new got %h want 00000000", cp0_rdata_o);
    end
    idle_inputs(); cp0_addr_i = 5'd3;
    #1;
    checks++;
    if (cp0_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mfc0_unimpl got %h want 00000000", cp0_rdata_o);
    end
    idle_inputs();
  endtask

  task automatic test_exc_eret_same();
    do_reset();
    valid_i = 1; pc_i = 32'h200; excode_i = 5'd10; eret_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_flush_o !== 1 || redirect_pc_o !== 32'h4180 || status_o[1] !== 1
        || epc_o !== 32'h200 || cause_o[6:2] !== 5'd10) begin
      errors++;
      $display("FAIL exc_over_eret got flush=%b rpc=%h exl=%b epc=%h code=%0d want 1 4180 1 200 10",
               exc_flush_o, redirect_pc_o, status_o[1], epc_o, cause_o[6:2]);
    end
    tick();
  endtask

  task automatic test_rst_in_take();
    valid_i = 1; eret_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_flush_o !== 1 || redirect_pc_o !== 32'h200) begin
      errors++;
      $display("FAIL eret_before_rst got %b %h want 1 00000200", exc_flush_o, redirect_pc_o);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({exc_flush_o, redirect_valid_o, redirect_pc_o} !== 34'h0
        || {status_o, cause_o, epc_o} !== 96'h0) begin
      errors++;
      $display("FAIL rst_in_ret got %b %b %h st=%h ca=%h epc=%h want all 0",
               exc_flush_o, redirect_valid_o, redirect_pc_o, status_o, cause_o, epc_o);
    end
    valid_i = 1; pc_i = 32'h300; excode_i = 5'd12;
    tick();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({exc_flush_o, redirect_valid_o, redirect_pc_o} !== 34'h0 || status_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_take got %b %b %h st=%h want 0 0 0 0",
               exc_flush_o, redirect_valid_o, redirect_pc_o, status_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    valid_i = 1; pc_i = 32'h0; in_delay_slot_i = 1; excode_i = 5'd4;
    tick();
    idle_inputs();
    checks++;
    if (epc_o !== 32'hffff_fffc || cause_o[31] !== 1) begin
      errors++;
      $display("FAIL epc_wrap got epc=%h bd=%b want fffffffc 1", epc_o, cause_o[31]);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_valid_low();
    test_syscall();
    test_mtc0_epc_eret();
    test_delay_slot();
    test_nested();
    test_mtc0_masks();
    test_exc_eret_same();
    test_rst_in_take();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
